apb4_master_bridge: RTL and testbench

//  APB4 initiator (requester). Converts single register commands on a valid/ready command channel into
//  APB4 SETUP/ACCESS transfers toward APB4 completers. Returns read data and error status on a

---
 rtl/apb4_pkg.sv | 23 ++
 rtl/apb4_mst_wdog.sv | 35 +++
 rtl/apb4_master_bridge.sv | 179 +++++++++++++++++
 tb/tb_apb4_master_bridge.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: FSM state encodings, PPROT bit positions and the
// default ACCESS watchdog limit. Used by both the initiator and completer blocks.
package apb4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb4_state_e;

    // Bit positions inside PPROT
    localparam int unsigned PPROT_PRIV   = 0;
    localparam int unsigned PPROT_NONSEC = 1;
    localparam int unsigned PPROT_INSTR  = 2;

    localparam int unsigned PPROT_W = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;

endpackage

// File: rtl/apb4_mst_wdog.sv
// ACCESS-phase watchdog for the APB4 initiator. The counter is cleared while the
// bus is in SETUP (i.e. on entry to ACCESS) and counts ACCESS cycles without
// pready. o_expire flags the cycle in which the limit is hit and pready is still
// low, so a pready arriving in that same cycle wins.
module apb4_mst_wdog
    import apb4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic pclk,
    input  logic presetn,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_pready,
    output logic o_expire
);

    localparam logic [15:0] Limit = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_count;

    // Count stalled ACCESS cycles since the last SETUP
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !i_pready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expire = i_en && !i_pready && (r_count == Limit);

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 initiator bridge: one command on the valid/ready command channel becomes
// one APB4 SETUP/ACCESS transfer, and its result is returned on the response
// channel. Only one transfer is ever outstanding.
// Optional feature: define APB4_MST_TIMEOUT_EN to abort ACCESS phases that stall
// for TIMEOUT_CYC cycles (reported as rsp_err=1, rsp_timeout=1).
module apb4_master_bridge
    import apb4_pkg::*;
#(
    parameter int unsigned ADDRWIDTH   = 12,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                 pclk,
    input  logic                 presetn,
    // Command channel
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_write,
    input  logic [ADDRWIDTH-1:0] i_cmd_addr,
    input  logic [31:0]          i_cmd_wdata,
    input  logic [3:0]           i_cmd_strb,
    input  logic [2:0]           i_cmd_prot,
    // Response channel
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_rsp_timeout,
    // APB4 requester interface
    output logic                 o_psel,
    output logic                 o_penable,
    output logic                 o_pwrite,
    output logic [ADDRWIDTH-1:0] o_paddr,
    output logic [31:0]          o_pwdata,
    output logic [3:0]           o_pstrb,
    output logic [2:0]           o_pprot,
    input  logic [31:0]          i_prdata,
    input  logic                 i_pready,
    input  logic                 i_pslverr
);

    apb4_state_e r_state;
    apb4_state_e w_state_next;

    logic                 w_accept;
    logic                 w_done;
    logic                 w_expire;

    logic [ADDRWIDTH-1:0] r_paddr;
    logic                 r_pwrite;
    logic [31:0]          r_pwdata;
    logic [3:0]           r_pstrb;
    logic [2:0]           r_pprot;

    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_rsp_timeout;

    assign w_accept = (r_state == ST_IDLE) && i_cmd_valid;
    // pready/pslverr/prdata only matter while in ACCESS
    assign w_done   = (r_state == ST_ACCESS) && i_pready;

`ifdef APB4_MST_TIMEOUT_EN
    logic w_wdog_clr;
    logic w_wdog_en;

    assign w_wdog_clr = (r_state == ST_SETUP);
    assign w_wdog_en  = (r_state == ST_ACCESS);

    apb4_mst_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .pclk     (pclk),
        .presetn  (presetn),
        .i_clr    (w_wdog_clr),
        .i_en     (w_wdog_en),
        .i_pready (i_pready),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    // Word alignment drops the byte offset
    logic w_unused_addr;
    assign w_unused_addr = ^i_cmd_addr[1:0];

    // FSM state register; async reset drops psel/penable immediately
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded handshake/bus control outputs
    always_comb begin
        w_state_next = r_state;
        o_cmd_ready  = 1'b0;
        o_psel       = 1'b0;
        o_penable    = 1'b0;
        o_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                o_psel       = 1'b1;
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_psel    = 1'b1;
                o_penable = 1'b1;
                if (i_pready || w_expire) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Transfer attributes: captured on accept, held until the next accept
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_accept) begin
            r_paddr  <= {i_cmd_addr[ADDRWIDTH-1:2], 2'b00};
            r_pwrite <= i_cmd_write;
            r_pwdata <= i_cmd_wdata;
            r_pstrb  <= i_cmd_write ? i_cmd_strb : 4'b0000;
            r_pprot  <= i_cmd_prot;
        end
    end

    // Response capture on completion or watchdog abort; held through RESP
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_rdata   <= r_pwrite ? 32'h0 : i_prdata;
            r_rsp_err     <= i_pslverr;
            r_rsp_timeout <= 1'b0;
        end else if ((r_state == ST_ACCESS) && w_expire) begin
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign o_pwrite      = r_pwrite;
    assign o_paddr       = r_paddr;
    assign o_pwdata      = r_pwdata;
    assign o_pstrb       = r_pstrb;
    assign o_pprot       = r_pprot;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: randomized commands and completer
// behaviour, checked against a transaction-level model of the bridge.
module tb_apb4_master_bridge;

    localparam int TO_CYC = 8;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 pclk = ~pclk;

    apb4_master_bridge #(
        .ADDRWIDTH   (12),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_write   (cmd_write),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .i_cmd_strb    (cmd_strb),
        .i_cmd_prot    (cmd_prot),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_psel        (psel),
        .o_penable     (penable),
        .o_pwrite      (pwrite),
        .o_paddr       (paddr),
        .o_pwdata      (pwdata),
        .o_pstrb       (pstrb),
        .o_pprot       (pprot),
        .i_prdata      (prdata),
        .i_pready      (pready),
        .i_pslverr     (pslverr)
    );

    typedef struct {
        bit          ready_before;
        int          setup_cyc;
        int          access_n;
        int          rsp_cyc;
        bit          stable;
        bit          psel_low_rsp;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        logic [11:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
        bit          hold_ok;
        bit          ready_after;
    } obs_t;

    typedef struct {
        logic [11:0] paddr;
        logic [3:0]  pstrb;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          access_n;
        int          rsp_cyc;
    } exp_t;

    // Transaction-level reference: what one command must produce.
    // waits < 0 means the completer never raises pready.
    function automatic exp_t model(input logic wr, input logic [11:0] addr, input logic [3:0] strb,
                                   input int waits, input logic [31:0] rd, input logic se);
        exp_t e;
        int   limit;
`ifdef APB4_MST_TIMEOUT_EN
        limit = TO_CYC;
`else
        limit = 0;
`endif
        e.paddr = addr & 12'hFFC;
        e.pstrb = wr ? strb : 4'h0;
        if (limit > 0 && (waits < 0 || waits + 1 > limit)) begin
            e.access_n = limit;
            e.rdata    = 32'h0;
            e.err      = 1'b1;
            e.to       = 1'b1;
        end else begin
            e.access_n = waits + 1;
            e.rdata    = wr ? 32'h0 : rd;
            e.err      = se;
            e.to       = 1'b0;
        end
        e.rsp_cyc = 2 + e.access_n;
        return e;
    endfunction

    // Drives one command and acts as the completer; cycle 0 is the accept edge.
    task automatic run_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int waits,
                            input logic [31:0] rd, input logic se, input int hold,
                            output obs_t o);
        int cyc;
        o = '{default: 0};
        o.setup_cyc = -1;
        o.rsp_cyc   = -1;
        o.stable    = 1;
        o.psel_low_rsp = 1;
        @(negedge pclk);
        o.ready_before = (cmd_ready === 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_strb = strb;  cmd_prot = prot; rsp_ready = 1'b0;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        @(posedge pclk);
        cyc = 0;
        while (o.rsp_cyc < 0 && cyc < 200) begin
            @(negedge pclk);
            cyc++;
            // Command inputs churn while busy and must be ignored
            cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
            cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
            if (psel === 1'b1 && penable === 1'b0 && o.setup_cyc < 0) begin
                o.setup_cyc = cyc;
                o.paddr = paddr; o.pwrite = pwrite; o.pwdata = pwdata;
                o.pstrb = pstrb; o.pprot = pprot;
            end
            if (psel === 1'b1 && penable === 1'b1) begin
                o.access_n++;
                if (paddr !== o.paddr || pwrite !== o.pwrite || pwdata !== o.pwdata ||
                    pstrb !== o.pstrb || pprot !== o.pprot) o.stable = 0;
                if (waits >= 0 && o.access_n == waits + 1) begin
                    pready = 1'b1; prdata = rd; pslverr = se;
                end else begin
                    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
                end
            end else begin
                if (rsp_valid === 1'b1) begin
                    o.rsp_cyc = cyc;
                    o.rdata = rsp_rdata; o.err = rsp_err; o.to = rsp_timeout;
                    if (psel !== 1'b0 || penable !== 1'b0) o.psel_low_rsp = 0;
                end
                pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
            end
        end
        o.hold_ok = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge pclk);
            @(negedge pclk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
                rsp_timeout !== o.to || cmd_ready !== 1'b0 || psel !== 1'b0 ||
                paddr !== o.paddr) o.hold_ok = 0;
            cmd_valid = 1'($urandom); cmd_addr = 12'($urandom);
            pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        pready    = 1'b0;
        o.ready_after = (cmd_ready === 1'b1 && rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0; cmd_prot = 0;
        rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
        repeat (2) @(negedge pclk);
        n_total++;
        if ({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=1000000",
                     {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        n_total++;
        if ({paddr, pwdata, pstrb, pprot, rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got=%h want=0", {paddr, pwdata, pstrb, pprot, rsp_rdata});
        end
        presetn = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        exp_t e;
        run_xfer(1'b1, 12'h004, 32'hA5A5_1234, 4'hF, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 0, o);
        e = model(1'b1, 12'h004, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
        n_total++;
        if (!o.ready_before) begin
            n_bad++; $display("FAIL wr0_ready_before got=0 want=1");
        end
        n_total++;
        if ({o.setup_cyc, o.access_n, o.rsp_cyc} !== {32'sd1, e.access_n, e.rsp_cyc}) begin
            n_bad++;
            $display("FAIL wr0_timing got=%0d/%0d/%0d want=1/%0d/%0d",
                     o.setup_cyc, o.access_n, o.rsp_cyc, e.access_n, e.rsp_cyc);
        end
        n_total++;
        if ({o.pwrite, o.pwdata, o.paddr, o.pstrb} !== {1'b1, 32'hA5A5_1234, e.paddr, e.pstrb}) begin
            n_bad++;
            $display("FAIL wr0_bus got=%b/%h/%h/%h want=1/a5a51234/%h/%h",
                     o.pwrite, o.pwdata, o.paddr, o.pstrb, e.paddr, e.pstrb);
        end
        n_total++;
        if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
            n_bad++;
            $display("FAIL wr0_rsp got=%h/%b/%b want=%h/%b/%b", o.rdata, o.err, o.to,
                     e.rdata, e.err, e.to);
        end
        n_total++;
        if (!o.ready_after || !o.psel_low_rsp) begin
            n_bad++;
            $display("FAIL wr0_release got=%b/%b want=1/1", o.ready_after, o.psel_low_rsp);
        end
    endtask

    task automatic test_read_waits();
        obs_t o;
        exp_t e;
        run_xfer(1'b0, 12'hFE0, 32'h1357_9BDF, 4'hF, 3'b101, 3, 32'h0000_0019, 1'b0, 0, o);
        e = model(1'b0, 12'hFE0, 4'hF, 3, 32'h0000_0019, 1'b0);
        n_total++;
        if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
            n_bad++;
            $display("FAIL rd3_rsp got=%h/%b/%b want=%h/%b/%b", o.rdata, o.err, o.to,
                     e.rdata, e.err, e.to);
        end
        n_total++;
        if ({o.paddr, o.pstrb, o.pprot, o.pwrite} !== {e.paddr, e.pstrb, 3'b101, 1'b0}) begin
            n_bad++;
            $display("FAIL rd3_bus got=%h/%h/%b/%b want=%h/%h/101/0", o.paddr, o.pstrb,
                     o.pprot, o.pwrite, e.paddr, e.pstrb);
        end
        n_total++;
        if (!o.stable || o.access_n != e.access_n || o.rsp_cyc != e.rsp_cyc) begin
            n_bad++;
            $display("FAIL rd3_access got=stable%0d/%0d/%0d want=stable1/%0d/%0d",
                     o.stable, o.access_n, o.rsp_cyc, e.access_n, e.rsp_cyc);
        end
    endtask

    task automatic test_error_unaligned();
        obs_t o;
        exp_t e;
        run_xfer(1'b1, 12'h00E, 32'h0BAD_F00D, 4'h3, 3'b010, 1, 32'hFFFF_FFFF, 1'b1, 0, o);
        e = model(1'b1, 12'h00E, 4'h3, 1, 32'hFFFF_FFFF, 1'b1);
        n_total++;
        if (o.paddr !== 12'h00C || o.paddr !== e.paddr) begin
            n_bad++; $display("FAIL err_paddr got=%h want=00c", o.paddr);
        end
        n_total++;
        if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
            n_bad++;
            $display("FAIL err_rsp got=%h/%b/%b want=%h/%b/%b", o.rdata, o.err, o.to,
                     e.rdata, e.err, e.to);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        obs_t o2;
        exp_t e;
        run_xfer(1'b0, 12'h200, 32'h0, 4'h0, 3'b000, 0, 32'h7777_1111, 1'b0, 5, o);
        n_total++;
        if (!o.hold_ok || !o.ready_after) begin
            n_bad++;
            $display("FAIL bp_hold got=%b/%b want=1/1", o.hold_ok, o.ready_after);
        end
        run_xfer(1'b1, 12'h204, 32'h2222_3333, 4'h5, 3'b001, 0, 32'h0, 1'b0, 0, o2);
        e = model(1'b1, 12'h204, 4'h5, 0, 32'h0, 1'b0);
        n_total++;
        if (!o2.ready_before || o2.setup_cyc != 1 || o2.paddr !== e.paddr || o2.pstrb !== e.pstrb) begin
            n_bad++;
            $display("FAIL bp_second got=%b/%0d/%h/%h want=1/1/%h/%h", o2.ready_before,
                     o2.setup_cyc, o2.paddr, o2.pstrb, e.paddr, e.pstrb);
        end
    endtask

    task automatic test_reset_mid_access();
        int  n;
        bit  saw_access;
        obs_t o;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h123; cmd_prot = 3'b011;
        pready = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        saw_access = 0;
        n = 0;
        while (!saw_access && n < 10) begin
            @(negedge pclk);
            n++;
            saw_access = (penable === 1'b1);
        end
        #2 presetn = 1'b0;
        #1;
        n_total++;
        if (!saw_access || psel !== 1'b0 || penable !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async got=access%0d/%b/%b want=access1/0/0", saw_access, psel, penable);
        end
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        n_total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || paddr !== 12'h000) begin
            n_bad++;
            $display("FAIL rst_after got=%b/%b/%h want=1/0/000", cmd_ready, rsp_valid, paddr);
        end
        run_xfer(1'b0, 12'h040, 32'h0, 4'h0, 3'b000, 0, 32'hCAFE_0001, 1'b0, 0, o);
        n_total++;
        if (o.rdata !== 32'hCAFE_0001 || o.rsp_cyc != 3) begin
            n_bad++;
            $display("FAIL rst_recover got=%h/%0d want=cafe0001/3", o.rdata, o.rsp_cyc);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            logic        wr;
            logic [11:0] addr;
            logic [31:0] wd;
            logic [31:0] rd;
            logic [3:0]  st;
            logic [2:0]  pr;
            logic        se;
            int          waits;
            int          hold;
            wr = 1'($urandom); addr = 12'($urandom); wd = $urandom; rd = $urandom;
            st = 4'($urandom); pr = 3'($urandom); se = ($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 4);
            hold = $urandom_range(0, 2);
            e = model(wr, addr, st, waits, rd, se);
            run_xfer(wr, addr, wd, st, pr, waits, rd, se, hold, o);
            n_total++;
            if ({o.paddr, o.pwrite, o.pwdata, o.pstrb, o.pprot} !== {e.paddr, wr, wd, e.pstrb, pr}) begin
                n_bad++;
                $display("FAIL b2b_bus[%0d] got=%h/%b/%h/%h/%h want=%h/%b/%h/%h/%h", i, o.paddr,
                         o.pwrite, o.pwdata, o.pstrb, o.pprot, e.paddr, wr, wd, e.pstrb, pr);
            end
            n_total++;
            if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to} ||
                o.access_n != e.access_n || o.rsp_cyc != e.rsp_cyc) begin
                n_bad++;
                $display("FAIL b2b_rsp[%0d] got=%h/%b/%b/%0d/%0d want=%h/%b/%b/%0d/%0d", i,
                         o.rdata, o.err, o.to, o.access_n, o.rsp_cyc,
                         e.rdata, e.err, e.to, e.access_n, e.rsp_cyc);
            end
            n_total++;
            if (!o.ready_before || !o.stable || !o.hold_ok || !o.ready_after || !o.psel_low_rsp) begin
                n_bad++;
                $display("FAIL b2b_proto[%0d] got=%b%b%b%b%b want=11111", i, o.ready_before,
                         o.stable, o.hold_ok, o.ready_after, o.psel_low_rsp);
            end
            // Bus attributes must hold while idle
            repeat (2) @(negedge pclk);
            n_total++;
            if (paddr !== e.paddr || pstrb !== e.pstrb || psel !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle[%0d] got=%h/%h/%b want=%h/%h/0", i, paddr, pstrb, psel,
                         e.paddr, e.pstrb);
            end
        end
    endtask

`ifdef APB4_MST_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        run_xfer(1'b0, 12'h300, 32'h0, 4'h0, 3'b000, -1, 32'h1234_5678, 1'b0, 0, o);
        e = model(1'b0, 12'h300, 4'h0, -1, 32'h1234_5678, 1'b0);
        n_total++;
        if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to} ||
            o.access_n != e.access_n || o.rsp_cyc != e.rsp_cyc) begin
            n_bad++;
            $display("FAIL to_abort got=%h/%b/%b/%0d/%0d want=%h/%b/%b/%0d/%0d", o.rdata, o.err,
                     o.to, o.access_n, o.rsp_cyc, e.rdata, e.err, e.to, e.access_n, e.rsp_cyc);
        end
        run_xfer(1'b0, 12'h304, 32'h0, 4'h0, 3'b000, TO_CYC - 1, 32'h8765_4321, 1'b0, 0, o);
        e = model(1'b0, 12'h304, 4'h0, TO_CYC - 1, 32'h8765_4321, 1'b0);
        n_total++;
        if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to} || o.access_n != e.access_n) begin
            n_bad++;
            $display("FAIL to_edge got=%h/%b/%b/%0d want=%h/%b/%b/%0d", o.rdata, o.err, o.to,
                     o.access_n, e.rdata, e.err, e.to, e.access_n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_error_unaligned();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
`ifdef APB4_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
